// File: rtl/passcode_checker.sv
// passcode_checker: holds the system passcode and the user's attempt as digit
// slots, compares them one digit per cycle on request, and counts consecutive
// failures into a lockout that end_sleep releases.
//
// state  | meaning
// IDLE   | accept digit entry, attempt clear and compare requests
// CHECK  | compare attempt[idx] against code[idx], one digit per cycle
// RESULT | present the one-cycle result pulse, clear attempt, update fail count
module passcode_checker #(
   parameter int DIGIT_W    = 2,
   parameter int NUM_DIGITS = 4,
   parameter int MAX_FAILS  = 3
) (
   input  logic                              clk,
   input  logic                              system_reset,
   input  logic                              store_value,
   input  logic                              input_value,
   input  logic                              compare,
   input  logic                              input_reset,
   input  logic                              end_sleep,
   input  logic [DIGIT_W-1:0]                bits,
   input  logic                              disp_sel,
   output logic [4*NUM_DIGITS-1:0]           disp_code,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   in_count,
   output logic                              code_valid,
   output logic                              busy,
   output logic                              correct_password,
   output logic                              incorrect_password,
   output logic                              lockout
);

   localparam int CW = $clog2(NUM_DIGITS+1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FW = $clog2(MAX_FAILS+1);
   localparam logic [CW-1:0] NUM_C    = CW'(NUM_DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS-1);
   localparam logic [FW-1:0] MAX_C    = FW'(MAX_FAILS);

   typedef enum logic [1:0] {IDLE, CHECK, RESULT} state_t;

   state_t               state_q, state_d;
   logic [DIGIT_W-1:0]   code_q [NUM_DIGITS];
   logic [DIGIT_W-1:0]   code_d [NUM_DIGITS];
   logic [DIGIT_W-1:0]   att_q  [NUM_DIGITS];
   logic [DIGIT_W-1:0]   att_d  [NUM_DIGITS];
   logic [CW-1:0]        scnt_q, scnt_d;
   logic [CW-1:0]        icnt_q, icnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 mis_q, mis_d;
   logic [FW-1:0]        fail_q, fail_d;

   assign busy               = (state_q != IDLE);
   assign correct_password   = (state_q == RESULT) && !mis_q;
   assign incorrect_password = (state_q == RESULT) && mis_q;
   assign lockout            = (fail_q == MAX_C);
   assign code_valid         = (scnt_q == NUM_C);
   assign in_count           = icnt_q;

   // Display mux: first-entered digit lands in the most significant nibble.
   always_comb begin
      disp_code = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         disp_code[4*(NUM_DIGITS-1-i) +: 4] = disp_sel ? 4'(code_q[i]) : 4'(att_q[i]);
      end
   end

   // Next-state logic for the FSM and all data registers.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      att_d   = att_q;
      scnt_d  = scnt_q;
      icnt_d  = icnt_q;
      idx_d   = idx_q;
      mis_d   = mis_q;
      fail_d  = fail_q;
      case (state_q)
         IDLE: begin
            if (store_value && (scnt_q < NUM_C)) begin
               code_d[scnt_q[IW-1:0]] = bits;
               scnt_d = scnt_q + CW'(1);
            end
            if (input_reset) begin
               for (int i = 0; i < NUM_DIGITS; i++) att_d[i] = '0;
               icnt_d = '0;
            end else if (compare) begin
               if (code_valid && !lockout) begin
                  state_d = CHECK;
                  idx_d   = '0;
                  mis_d   = (icnt_q != NUM_C);
               end
            end else if (input_value && (icnt_q < NUM_C) && !lockout) begin
               att_d[icnt_q[IW-1:0]] = bits;
               icnt_d = icnt_q + CW'(1);
            end
         end
         CHECK: begin
            mis_d = mis_q | (att_q[idx_q] != code_q[idx_q]);
            idx_d = idx_q + IW'(1);
            if (idx_q == LAST_IDX) state_d = RESULT;
         end
         RESULT: begin
            state_d = IDLE;
            for (int i = 0; i < NUM_DIGITS; i++) att_d[i] = '0;
            icnt_d = '0;
            if (mis_q) fail_d = (fail_q == MAX_C) ? fail_q : fail_q + FW'(1);
            else       fail_d = '0;
         end
         default: state_d = IDLE;
      endcase
      // Release from sleep overrides any fail-count update in the same cycle.
      if (end_sleep) fail_d = '0;
   end

   // State and data registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (system_reset) begin
         state_q <= IDLE;
         scnt_q  <= '0;
         icnt_q  <= '0;
         idx_q   <= '0;
         mis_q   <= 1'b0;
         fail_q  <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            code_q[i] <= '0;
            att_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         icnt_q  <= icnt_d;
         idx_q   <= idx_d;
         mis_q   <= mis_d;
         fail_q  <= fail_d;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            code_q[i] <= code_d[i];
            att_q[i]  <= att_d[i];
         end
      end
   end

endmodule

// File: tb/tb_passcode_checker.sv
// Bench for passcode_checker: directed stimulus pushes expected result pulses
// (kind and cycle) into a queue; a negedge monitor pops and checks them.
module tb_passcode_checker;

   logic        clk = 1'b0;
   logic        system_reset = 1'b1;
   logic        store_value = 1'b0, input_value = 1'b0, compare = 1'b0;
   logic        input_reset = 1'b0, end_sleep = 1'b0, disp_sel = 1'b0;
   logic [1:0]  bits = 2'd0;
   logic [15:0] disp_code;
   logic [2:0]  in_count;
   logic        code_valid, busy, correct_password, incorrect_password, lockout;

   typedef struct {logic ok; int cyc;} exp_t;
   exp_t exp_q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   passcode_checker dut (
      .clk(clk), .system_reset(system_reset), .store_value(store_value),
      .input_value(input_value), .compare(compare), .input_reset(input_reset),
      .end_sleep(end_sleep), .bits(bits), .disp_sel(disp_sel),
      .disp_code(disp_code), .in_count(in_count), .code_valid(code_valid),
      .busy(busy), .correct_password(correct_password),
      .incorrect_password(incorrect_password), .lockout(lockout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input int d);
      bits = 2'(d); store_value = 1'b1; tick(); store_value = 1'b0;
   endtask

   task automatic enter(input int d);
      bits = 2'(d); input_value = 1'b1; tick(); input_value = 1'b0;
   endtask

   task automatic enter_code(input int a, input int b, input int c, input int d);
      enter(a); enter(b); enter(c); enter(d);
   endtask

   // Issue compare, expect a result pulse in cycle 5 and busy for cycles 1..5.
   task automatic run_compare(input logic exp_ok, input logic es_at_result);
      exp_t e;
      e.ok = exp_ok; e.cyc = cyc + 5;
      exp_q.push_back(e);
      compare = 1'b1; tick(); compare = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         chk("busy_during_compare", 32'(busy), 32'd1);
         if (c == 5 && es_at_result) end_sleep = 1'b1;
         tick();
         end_sleep = 1'b0;
      end
      chk("busy_after_result", 32'(busy), 32'd0);
      chk("in_count_after_result", 32'(in_count), 32'd0);
   endtask

   // Monitor: every result pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (correct_password || incorrect_password) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result_pulse", {30'd0, correct_password, incorrect_password}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_correct", 32'(correct_password), 32'(e.ok));
            chk("result_incorrect", 32'(incorrect_password), 32'(!e.ok));
            chk("result_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      tick(); tick();
      system_reset = 1'b0;
      chk("rst_disp_att", 32'(disp_code), 32'h0);
      disp_sel = 1'b1; #1;
      chk("rst_disp_code", 32'(disp_code), 32'h0);
      chk("rst_in_count", 32'(in_count), 32'd0);
      chk("rst_code_valid", 32'(code_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_lockout", 32'(lockout), 32'd0);
      chk("rst_pulses", {30'd0, correct_password, incorrect_password}, 32'd0);

      // compare without a valid code is ignored
      compare = 1'b1; tick(); compare = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("busy_no_code", 32'(busy), 32'd0);
         tick();
      end

      store(3); store(1); store(0); store(2);
      chk("code_valid", 32'(code_valid), 32'd1);
      chk("disp_code_sys", 32'(disp_code), 32'h3102);
      store(1);
      chk("disp_code_5th_store", 32'(disp_code), 32'h3102);
      disp_sel = 1'b0; #1;
      chk("disp_attempt_empty", 32'(disp_code), 32'h0);

      enter_code(3, 1, 0, 2);
      chk("disp_attempt_full", 32'(disp_code), 32'h3102);
      chk("in_count_full", 32'(in_count), 32'd4);
      run_compare(1'b1, 1'b0);
      chk("disp_attempt_cleared", 32'(disp_code), 32'h0);

      enter_code(3, 1, 2, 2);
      run_compare(1'b0, 1'b0);
      chk("lockout_after_1", 32'(lockout), 32'd0);

      enter(3); enter(1);
      chk("in_count_partial", 32'(in_count), 32'd2);
      run_compare(1'b0, 1'b0);
      chk("lockout_after_2", 32'(lockout), 32'd0);

      enter_code(0, 0, 0, 0);
      run_compare(1'b0, 1'b0);
      chk("lockout_after_3", 32'(lockout), 32'd1);

      enter(3);
      chk("in_count_locked", 32'(in_count), 32'd0);
      compare = 1'b1; tick(); compare = 1'b0;
      chk("busy_locked_c1", 32'(busy), 32'd0);
      tick();
      chk("busy_locked_c2", 32'(busy), 32'd0);

      end_sleep = 1'b1; tick(); end_sleep = 1'b0;
      chk("lockout_released", 32'(lockout), 32'd0);
      enter_code(3, 1, 0, 2);
      run_compare(1'b1, 1'b0);

      // end_sleep coinciding with the locking result wins
      enter_code(1, 1, 1, 1); run_compare(1'b0, 1'b0);
      enter_code(1, 1, 1, 1); run_compare(1'b0, 1'b0);
      enter_code(1, 1, 1, 1); run_compare(1'b0, 1'b1);
      chk("lockout_end_sleep_wins", 32'(lockout), 32'd0);

      // reset during CHECK: no pulse, everything cleared
      enter_code(3, 1, 0, 2);
      compare = 1'b1; tick(); compare = 1'b0;
      tick();
      system_reset = 1'b1; tick(); system_reset = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_code_valid", 32'(code_valid), 32'd0);
      chk("midrst_in_count", 32'(in_count), 32'd0);
      chk("midrst_pulses", {30'd0, correct_password, incorrect_password}, 32'd0);
      chk("midrst_disp", 32'(disp_code), 32'h0);
      tick(); tick(); tick(); tick();

      // input_reset beats input_value in the same cycle
      store(2); store(2); store(1); store(3);
      enter(1); enter(2);
      chk("in_count_two", 32'(in_count), 32'd2);
      chk("disp_two", 32'(disp_code), 32'h1200);
      bits = 2'd3; input_value = 1'b1; input_reset = 1'b1;
      tick();
      input_value = 1'b0; input_reset = 1'b0;
      chk("in_count_after_ireset", 32'(in_count), 32'd0);
      chk("disp_after_ireset", 32'(disp_code), 32'h0);

      tick(); tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
